// File: rtl/score_digit_ctrl.sv
// Score-to-BCD controller: on a score change, runs a 16-step double-dabble
// conversion and publishes five registered decimal digits with a done pulse.
module score_digit_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score_in,
    input  logic        game_start,
    output logic [3:0]  digit_0,
    output logic [3:0]  digit_1,
    output logic [3:0]  digit_2,
    output logic [3:0]  digit_3,
    output logic [3:0]  digit_4,
    output logic        digits_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] last_q, last_d;
    logic [35:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        force_q, force_d;
    logic [19:0] digits_q, digits_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    // One double-dabble iteration: per-nibble add-3 (no inter-nibble carry), then shift.
    function automatic logic [35:0] dabble_step(input logic [35:0] s);
        logic [35:0] t;
        t = s;
        for (int i = 0; i < 5; i++) begin
            if (t[16+4*i +: 4] >= 4'd5)
                t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
        end
        return {t[34:0], 1'b0};
    endfunction

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        force_d  = force_q;
        digits_d = digits_q;
        valid_d  = valid_q;
        done_d   = 1'b0;

        if (!game_start) begin
            // Abort and blank; the next game must convert at least once, even for 0.
            state_d  = IDLE;
            digits_d = '0;
            valid_d  = 1'b0;
            last_d   = '0;
            force_d  = 1'b1;
            cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (force_q || (score_in != last_q)) begin
                        shreg_d = {20'h0, score_in};
                        last_d  = score_in;
                        force_d = 1'b0;
                        cnt_d   = '0;
                        state_d = CONV;
                    end
                end
                CONV: begin
                    shreg_d = dabble_step(shreg_q);
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd15)
                        state_d = DONE;
                end
                DONE: begin
                    digits_d = shreg_q[35:16];
                    valid_d  = 1'b1;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= '0;
            shreg_q  <= '0;
            cnt_q    <= '0;
            force_q  <= 1'b0;
            digits_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            force_q  <= force_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign digit_0      = digits_q[19:16];
    assign digit_1      = digits_q[15:12];
    assign digit_2      = digits_q[11:8];
    assign digit_3      = digits_q[7:4];
    assign digit_4      = digits_q[3:0];
    assign digits_valid = valid_q;
    assign done         = done_q;
    assign busy         = (state_q == CONV) || (state_q == DONE);

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Self-checking bench for score_digit_ctrl: directed and random scores checked
// against decimal digits computed by integer division.
module tb_score_digit_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] score_in;
    logic        game_start;
    logic [3:0]  digit_0, digit_1, digit_2, digit_3, digit_4;
    logic        digits_valid, busy, done;

    int vectors     = 0;
    int miscompares = 0;

    logic [19:0] exp_dig;
    logic        exp_valid;
    logic [15:0] cur_score;

    score_digit_ctrl dut (
        .clk(clk), .rst_n(rst_n), .score_in(score_in), .game_start(game_start),
        .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2),
        .digit_3(digit_3), .digit_4(digit_4),
        .digits_valid(digits_valid), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [19:0] dig_obs = {digit_0, digit_1, digit_2, digit_3, digit_4};

    function automatic logic [19:0] ref_bcd(input int v);
        logic [3:0] d0, d1, d2, d3, d4;
        d0 = 4'((v / 10000) % 10);
        d1 = 4'((v / 1000) % 10);
        d2 = 4'((v / 100) % 10);
        d3 = 4'((v / 10) % 10);
        d4 = 4'(v % 10);
        return {d0, d1, d2, d3, d4};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; game_start = 1'b1; score_in = 16'd0;
        #23;
        vectors++;
        if (dig_obs !== 20'h0 || digits_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: dig=%h valid=%b done=%b busy=%b, required 00000/0/0/0",
                     dig_obs, digits_valid, done, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        exp_dig = 20'h0; exp_valid = 1'b0; cur_score = 16'd0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            vectors++;
            if (dig_obs !== 20'h0 || digits_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_after_reset c%0d: dig=%h valid=%b done=%b busy=%b, required 00000/0/0/0",
                         k, dig_obs, digits_valid, done, busy);
            end
        end
    endtask

    task automatic test_convert;
        int vals[$];
        int v;
        vals = '{12345, 65535, 9999, 10000};
        for (int r = 0; r < 6; r++) vals.push_back(int'($urandom_range(0, 65535)));
        foreach (vals[i]) begin
            v = vals[i];
            if (v == int'(cur_score)) v = v ^ 1;
            score_in = 16'(v);
            for (int k = 1; k <= 19; k++) begin
                @(negedge clk);
                vectors++;
                if (busy !== (k <= 17) || done !== (k == 18)) begin
                    miscompares++;
                    $display("FAIL conv_timing v=%0d c%0d: busy=%b done=%b, required busy=%b done=%b",
                             v, k, busy, done, (k <= 17), (k == 18));
                end
                if (k == 18) begin
                    exp_dig = ref_bcd(v); exp_valid = 1'b1;
                end
                vectors++;
                if (dig_obs !== exp_dig || digits_valid !== exp_valid) begin
                    miscompares++;
                    $display("FAIL conv_digits v=%0d c%0d: dig=%h valid=%b, required %h/%b",
                             v, k, dig_obs, digits_valid, exp_dig, exp_valid);
                end
            end
            cur_score = 16'(v);
        end
    endtask

    task automatic test_back_to_back;
        score_in = 16'd100;
        repeat (20) @(negedge clk);
        exp_dig = ref_bcd(100);
        score_in = 16'd101;
        for (int k = 1; k <= 37; k++) begin
            @(negedge clk);
            if (k == 18) exp_dig = ref_bcd(101);
            if (k == 36) exp_dig = ref_bcd(102);
            vectors++;
            if (done !== (k == 18 || k == 36) ||
                busy !== ((k >= 1 && k <= 17) || (k >= 19 && k <= 35)) ||
                dig_obs !== exp_dig || digits_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL back_to_back c%0d: done=%b busy=%b dig=%h valid=%b, required done=%b busy=%b dig=%h valid=1",
                         k, done, busy, dig_obs, digits_valid, (k == 18 || k == 36),
                         ((k >= 1 && k <= 17) || (k >= 19 && k <= 35)), exp_dig);
            end
            if (k == 5) score_in = 16'd102;
        end
        cur_score = 16'd102;
    endtask

    task automatic test_abort;
        score_in = 16'd500;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 11) begin exp_dig = 20'h0; exp_valid = 1'b0; end
            vectors++;
            if (done !== 1'b0 || dig_obs !== exp_dig || digits_valid !== exp_valid ||
                busy !== (k <= 10)) begin
                miscompares++;
                $display("FAIL abort c%0d: done=%b busy=%b dig=%h valid=%b, required done=0 busy=%b dig=%h valid=%b",
                         k, done, busy, dig_obs, digits_valid, (k <= 10), exp_dig, exp_valid);
            end
            if (k == 10) game_start = 1'b0;
        end
        score_in = 16'd0;
        game_start = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 18) exp_valid = 1'b1;
            vectors++;
            if (done !== (k == 18) || dig_obs !== 20'h0 || digits_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL forced_zero c%0d: done=%b dig=%h valid=%b, required done=%b dig=00000 valid=%b",
                         k, done, dig_obs, digits_valid, (k == 18), exp_valid);
            end
        end
        cur_score = 16'd0;
    endtask

    task automatic test_reset_mid;
        score_in = 16'd4321;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (dig_obs !== 20'h0 || digits_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: dig=%h valid=%b done=%b busy=%b, required 00000/0/0/0",
                     dig_obs, digits_valid, done, busy);
        end
        score_in = 16'd0;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || digits_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle c%0d: busy=%b done=%b valid=%b, required 0/0/0",
                         k, busy, done, digits_valid);
            end
        end
        score_in = 16'd7;
        exp_dig = 20'h0; exp_valid = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (k == 18) begin exp_dig = ref_bcd(7); exp_valid = 1'b1; end
            vectors++;
            if (done !== (k == 18) || dig_obs !== exp_dig || digits_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL post_reset_conv c%0d: done=%b dig=%h valid=%b, required done=%b dig=%h valid=%b",
                         k, done, dig_obs, digits_valid, (k == 18), exp_dig, exp_valid);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; game_start = 1'b0; score_in = 16'd0;
        exp_dig = 20'h0; exp_valid = 1'b0; cur_score = 16'd0;
        test_reset();
        test_convert();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_digit_ctrl.md
# score_digit_ctrl

Sequential score-to-decimal controller between the game logic score counter and the on-screen character ROM. It detects a change on the 16-bit score and runs a 16-step shift-and-add-3 (double-dabble) conversion. It then publishes five registered BCD digits, and a done pulse, for the character path to render after the "SCORE:" label. This replaces wide combinational dividers with one small iterative datapath and a three-state FSM.

## Interface
- No parameters; widths fixed: score 16 bits, 5 BCD digits of 4 bits.
- clk  input  1  system pixel/logic clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- score_in  input  16  binary score from game logic, unsigned, sampled only in IDLE.
- game_start  input  1  high while a game is running; low aborts and blanks.
- digit_0  output  4  ten-thousands BCD digit (leftmost on screen).
- digit_1  output  4  thousands digit.
- digit_2  output  4  hundreds digit.
- digit_3  output  4  tens digit.
- digit_4  output  4  units digit.
- digits_valid  output  1  digit outputs hold a completed conversion of the current game.
- busy  output  1  high in CONV and DONE.
- done  output  1  one-cycle pulse when new digits appear.

## Operation
- Internal registers:
  - state (IDLE, CONV, DONE);
  - last_score[15:0], the value last converted;
  - shreg[35:0], with BCD in [35:16] and binary in [15:0];
  - cnt[4:0];
  - force, a pending forced conversion.
- Reset (rst_n low, asynchronous): state=IDLE; all digits=0; digits_valid=0; busy=0; done=0; last_score=0; cnt=0; force=0.
- game_start low, any state:
  - next state IDLE;
  - conversion abandoned;
  - digits=0 and digits_valid=0;
  - last_score=0;
  - force=1, so that the next game always converts once, even for score 0.
- IDLE with game_start high:
  - Start a conversion if force=1 or score_in != last_score.
  - On start: shreg <= {20'h0, score_in}; last_score <= score_in; force <= 0; cnt <= 0; state <= CONV.
  - Otherwise, stay in IDLE.
- CONV: each cycle performs one iteration.
  - First, each of the 5 BCD nibbles of shreg that is >= 5 gets +3.
  - Then the whole 36-bit register shifts left by 1.
  - cnt increments. After the iteration with cnt=15, state <= DONE.
- DONE:
  - digit_0..digit_4 <= shreg[35:32], [31:28], [27:24], [23:20], [19:16];
  - digits_valid <= 1; done pulses; state <= IDLE.
- A score_in change during CONV/DONE is not sampled. The IDLE comparison against last_score catches it on return, so the final score is always converted.
- Digit outputs change only on the DONE edge, or clear on game_start low or reset. They never show partial conversion results.
- Arithmetic: the add-3 is applied per nibble and never carries across nibbles. The result is exact for 0..65535; max output is 6,5,5,3,5.

## Timing
- busy is combinational from state (CONV or DONE); the outputs are registered.
- Let cycle N be the IDLE cycle in which a difference (or force) is seen:
  - CONV occupies cycles N+1..N+16;
  - DONE is cycle N+17;
  - new digits, digits_valid and done are visible in cycle N+18, when state is back in IDLE.
- Latency is 18 cycles from sampling to visible digits. The minimum spacing between consecutive done pulses is 18 cycles.
- Back-to-back changes: IDLE in cycle N+18 can start the next conversion immediately.
- game_start falling in any cycle:
  - outputs clear on the following edge;
  - done is never asserted for an aborted conversion.
  - If game_start falls in DONE, DONE's output load is suppressed; the outputs clear instead.
- rst_n asserted mid-conversion: everything clears immediately, asynchronously. After release, nothing converts until game_start is high (force=0 after reset). Reset does not set force; a 0-score game started directly after reset shows the default 0 digits, with digits_valid low until the first score change.

## Test plan
- Reset, game_start=1, score_in=0: no conversion. Digits 0,0,0,0,0 with digits_valid=0, held for 100 cycles; done never pulses.
- score_in 0 -> 12345 in cycle N: busy during N+1..N+17; done exactly at N+18. Digits 1,2,3,4,5 with digits_valid=1.
- score_in=65535: digits 6,5,5,3,5. Then 9999: digits 0,9,9,9,9. Then 10000: digits 1,0,0,0,0.
- score_in 100 -> 101 in cycle N, then 102 at N+5: the first done at N+18 shows 1,0,1. The second conversion starts at N+18; the second done is at N+36 and shows 1,0,2.
- game_start dropped at N+10 during a conversion of 500: no done; digits clear to 0 and digits_valid=0 next cycle. Raise game_start with score_in=0: a forced conversion gives done 18 cycles later, digits 0,0,0,0,0 with digits_valid=1.
- rst_n pulsed low at N+8 mid-conversion: all outputs 0 within the same cycle, without waiting for a clock edge. After release, a score change to 7 gives digits 0,0,0,0,7 after 18 cycles.
